// File: rtl/misao_mem_pkg.sv
// misao_mem_pkg: shared boot FSM type, default core address width and pointer sizing
package misao_mem_pkg;
  typedef enum logic [1:0] {CLEAR, LOAD, RUN} boot_state_e;
  localparam int DEF_ADDR_W = 15;
  function automatic int ptr_w(input int depth);
    return $clog2(depth);
  endfunction
endpackage

// File: rtl/misao_sp_ram.sv
// misao_sp_ram: single-port byte array, registered read-before-write, optional zero read
module misao_sp_ram import misao_mem_pkg::*; #(
  parameter int DEPTH = 256
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       we,
  input  logic                       re,
  input  logic                       rz,
  input  logic [ptr_w(DEPTH)-1:0]    addr,
  input  logic [7:0]                 wdata,
  output logic [7:0]                 rdata
);
  logic [7:0] mem [DEPTH];
  logic [7:0] rdata_q, rdata_d;
  always_comb rdata_d = re ? (rz ? 8'h00 : mem[addr]) : rdata_q;
  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
    if (rst) rdata_q <= 8'h00;
    else rdata_q <= rdata_d;
  end
  assign rdata = rdata_q;
endmodule

// File: rtl/misao_boot_ram.sv
// misao_boot_ram: core byte memory that zero-fills, loads a boot image, then serves the core
module misao_boot_ram import misao_mem_pkg::*; #(
  parameter int ADDR_W         = DEF_ADDR_W,
  parameter int DEPTH          = 256,
  parameter int CLEAR_ON_RESET = 1,
  parameter int BOOT_EN        = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mem_enable_read,
  input  logic              mem_enable_write,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_rw,
  input  logic [7:0]        mem_data_out,
  output logic [7:0]        mem_data_in,
  input  logic              ld_valid,
  output logic              ld_ready,
  input  logic [7:0]        ld_data,
  input  logic              ld_last,
  output logic              core_rst,
  output logic              boot_done,
  output logic              oob_err
);
  localparam int PW = ptr_w(DEPTH);
  localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);
  localparam boot_state_e POST_CLEAR = BOOT_EN != 0 ? LOAD : RUN;
  localparam boot_state_e RST_STATE = CLEAR_ON_RESET != 0 ? CLEAR : POST_CLEAR;
  boot_state_e state_q, state_d;
  logic [PW-1:0] ptr_q, ptr_d, ram_addr;
  logic ld_ready_q, ld_ready_d, core_rst_q, core_rst_d;
  logic boot_done_q, boot_done_d, oob_err_q, oob_err_d;
  logic hs, oob, ram_we, ram_re, unused_rw;
  logic [7:0] ram_wdata;
  assign unused_rw = mem_rw;
  assign hs = state_q == LOAD && ld_valid && ld_ready_q;
  assign oob = {1'b0, mem_addr} >= (ADDR_W + 1)'(DEPTH);
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= RST_STATE;
      ptr_q       <= '0;
      ld_ready_q  <= 1'b0;
      core_rst_q  <= 1'b1;
      boot_done_q <= 1'b0;
      oob_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      ld_ready_q  <= ld_ready_d;
      core_rst_q  <= core_rst_d;
      boot_done_q <= boot_done_d;
      oob_err_q   <= oob_err_d;
    end
  end
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    if (state_q == CLEAR) begin
      ptr_d   = ptr_q == LAST ? '0 : ptr_q + 1'b1;
      state_d = ptr_q == LAST ? POST_CLEAR : CLEAR;
    end else if (hs) begin
      ptr_d   = ptr_q + 1'b1;
      state_d = (ld_last || ptr_q == LAST) ? RUN : LOAD;
    end
  end
  // Handshake outputs are registered from the next state so they flip on the transition edge
  always_comb begin
    ld_ready_d  = state_d == LOAD;
    core_rst_d  = state_d != RUN;
    boot_done_d = state_d == RUN;
    oob_err_d   = state_q == RUN && (mem_enable_read || mem_enable_write) && oob;
    ram_we      = !rst && (state_q == CLEAR || hs || (state_q == RUN && mem_enable_write && !oob));
    ram_re      = !rst && state_q == RUN && mem_enable_read;
    ram_wdata   = state_q == CLEAR ? 8'h00 : state_q == LOAD ? ld_data : mem_data_out;
    ram_addr    = state_q == RUN ? mem_addr[PW-1:0] : ptr_q;
  end
  misao_sp_ram #(.DEPTH(DEPTH)) u_ram (
    .clk   (clk),
    .rst   (rst),
    .we    (ram_we),
    .re    (ram_re),
    .rz    (oob),
    .addr  (ram_addr),
    .wdata (ram_wdata),
    .rdata (mem_data_in)
  );
  assign ld_ready  = ld_ready_q;
  assign core_rst  = core_rst_q;
  assign boot_done = boot_done_q;
  assign oob_err   = oob_err_q;
endmodule

// File: tb/tb_misao_boot_ram.sv
// tb_misao_boot_ram: random and directed stimulus checked against a behavioural memory model
module tb_misao_boot_ram;
  localparam int DEPTH = 256;
  logic clk = 0, rst = 1;
  logic rd = 0, wr = 0, rw = 0, ld_valid = 0, ld_last = 0;
  logic [14:0] addr = '0;
  logic [7:0] wd = '0, ld_data = '0;
  logic [7:0] mem_data_in;
  logic ld_ready, core_rst, boot_done, oob_err;
  int total = 0, bad = 0;
  logic chk_en = 0;
  logic [7:0] prog [11] = '{8'h18, 8'h0C, 8'h54, 8'hC8, 8'h04, 8'hC0, 8'h94, 8'hC8, 8'h04, 8'hC0, 8'h00};

  misao_boot_ram #(.ADDR_W(15), .DEPTH(DEPTH), .CLEAR_ON_RESET(1), .BOOT_EN(1)) dut (
    .clk(clk), .rst(rst), .mem_enable_read(rd), .mem_enable_write(wr), .mem_addr(addr),
    .mem_rw(rw), .mem_data_out(wd), .mem_data_in(mem_data_in), .ld_valid(ld_valid),
    .ld_ready(ld_ready), .ld_data(ld_data), .ld_last(ld_last), .core_rst(core_rst),
    .boot_done(boot_done), .oob_err(oob_err)
  );

  always #5 clk = ~clk;

  // Model: 0 = zero-filling, 1 = loading, 2 = serving the core
  int mode = 0, cnt = 0;
  logic [7:0] m_mem [DEPTH];
  logic [7:0] e_data;
  logic e_rdy, e_crst, e_done, e_oob;

  always @(posedge clk) begin
    if (rst) begin
      mode <= 0; cnt <= 0; e_rdy <= 0; e_crst <= 1; e_done <= 0; e_oob <= 0; e_data <= 0;
    end else if (mode == 0) begin
      m_mem[cnt] <= 8'h00;
      cnt <= (cnt == DEPTH - 1) ? 0 : cnt + 1;
      if (cnt == DEPTH - 1) begin mode <= 1; e_rdy <= 1; end
    end else if (mode == 1) begin
      if (ld_valid && e_rdy) begin
        m_mem[cnt] <= ld_data;
        cnt <= cnt + 1;
        if (ld_last || cnt == DEPTH - 1) begin
          mode <= 2; e_rdy <= 0; e_crst <= 0; e_done <= 1;
        end
      end
    end else begin
      e_oob <= (rd || wr) && int'(addr) >= DEPTH;
      if (rd) e_data <= int'(addr) >= DEPTH ? 8'h00 : m_mem[addr[7:0]];
      if (wr && int'(addr) < DEPTH) m_mem[addr[7:0]] <= wd;
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%0h exp=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) if (chk_en) begin
    chk("m_data", mem_data_in, e_data);
    chk("m_oob", oob_err, e_oob);
    chk("m_ready", ld_ready, e_rdy);
    chk("m_core_rst", core_rst, e_crst);
    chk("m_boot_done", boot_done, e_done);
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic wait_clear();
    int nz = 0;
    repeat (DEPTH - 1) tick();
    chk("pre_ready", ld_ready, 0);
    chk("pre_core_rst", core_rst, 1);
    tick();
    chk("ready_rise", ld_ready, 1);
    for (int i = 0; i < DEPTH; i++) if (dut.u_ram.mem[i] !== 8'h00) nz++;
    chk("clear_nonzero", nz, 0);
  endtask

  task automatic load_prog(input bit rand_gap);
    for (int i = 0; i < 11; i++) begin
      ld_valid = 1; ld_data = prog[i]; ld_last = (i == 10);
      tick();
      ld_valid = 0; ld_last = 0;
      if (i == 10) begin
        chk("ld_boot_done", boot_done, 1);
        chk("ld_core_rst", core_rst, 0);
        chk("ld_ready_fall", ld_ready, 0);
      end else chk("ld_hold_rst", core_rst, 1);
      repeat (rand_gap ? $urandom_range(0, 3) : 2) tick();
    end
    for (int i = 0; i < 11; i++) chk("bd_prog", dut.u_ram.mem[i], prog[i]);
    chk("bd_after", dut.u_ram.mem[11], 8'h00);
  endtask

  task automatic run_op(input logic r, input logic w, input logic [14:0] a, input logic [7:0] d);
    rd = r; wr = w; addr = a; wd = d;
    tick();
    rd = 0; wr = 0;
  endtask

  task automatic rand_traffic(input int n);
    for (int i = 0; i < n; i++)
      run_op($urandom_range(0, 1), $urandom_range(0, 1),
             ($urandom_range(0, 3) == 0) ? 15'($urandom_range(DEPTH, 32767)) : 15'($urandom_range(0, DEPTH - 1)),
             8'($urandom));
  endtask

  initial begin
    tick();
    chk_en = 1;
    repeat (4) tick();
    chk("rst_data", mem_data_in, 0);
    chk("rst_core_rst", core_rst, 1);
    chk("rst_ready", ld_ready, 0);
    rst = 0;
    wait_clear();
    load_prog(0);
    run_op(0, 1, 15'h0000, 8'h05);
    run_op(1, 0, 15'h0000, 8'h00);
    chk("rd_5", mem_data_in, 8'h05);
    run_op(1, 1, 15'h0000, 8'h09);
    chk("rbw_old", mem_data_in, 8'h05);
    run_op(1, 0, 15'h0000, 8'h00);
    chk("rbw_new", mem_data_in, 8'h09);
    run_op(0, 1, 15'h0100, 8'hAA);
    chk("oob_wr_pulse", oob_err, 1);
    chk("oob_wr_drop", dut.u_ram.mem[0], 8'h09);
    tick();
    chk("oob_wr_end", oob_err, 0);
    run_op(1, 0, 15'h0100, 8'h00);
    chk("oob_rd_data", mem_data_in, 8'h00);
    chk("oob_rd_pulse", oob_err, 1);
    tick();
    chk("oob_rd_end", oob_err, 0);
    ld_valid = 1; ld_data = 8'h77;
    tick();
    ld_valid = 0;
    chk("run_ld_ignored", ld_ready, 0);
    rand_traffic(300);
    rst = 1; tick(); rst = 0;
    wait_clear();
    for (int i = 0; i < 3; i++) begin
      ld_valid = 1; ld_data = 8'($urandom);
      tick();
    end
    ld_valid = 0; rst = 1;
    tick();
    chk("mid_rst_ready", ld_ready, 0);
    chk("mid_rst_core_rst", core_rst, 1);
    rst = 0;
    wait_clear();
    load_prog(1);
    for (int i = 0; i < 12; i++) begin
      run_op(1, 0, 15'(i), 8'h00);
      chk("fd_prog", mem_data_in, i < 11 ? prog[i] : 8'h00);
    end
    rst = 1; tick(); rst = 0;
    wait_clear();
    for (int i = 0; i < DEPTH; i++) begin
      ld_valid = 1; ld_data = 8'($urandom);
      tick();
      ld_valid = 0;
      if (i == DEPTH - 2) chk("full_not_done", boot_done, 0);
      if ($urandom_range(0, 1) == 1 && i != DEPTH - 1) tick();
    end
    chk("full_done", boot_done, 1);
    rand_traffic(300);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
